ttl_serial_parity_checker: RTL
==============================

# ttl_serial_parity_checker

Bit-serial parity receiver/checker: deserializes frames of DATA_WIDTH data bits followed by one parity bit, checks parity against a selectable odd/even mode, and presents the word with an error flag on a valid/ready output. It is the receiving end of the team's parity-generator parts: a sender appends the generated parity bit, and this block verifies it. It also keeps a saturating parity-error count and a sticky overrun flag.

## Interface
- DATA_WIDTH, 8, data bits per frame; frame length is DATA_WIDTH+1.
- ERR_CNT_WIDTH, 8, width of saturating parity-error counter.

- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- SIN  in  1  serial bit, LSB first, parity bit last.
- SVALID  in  1  SIN qualifier; bits are accepted only when high.
- START  in  1  marks first data bit of a frame; meaningful only with SVALID=1.
- ODD_MODE  in  1  1 = expect odd count of ones over data+parity; 0 = even.
- DOUT  out  DATA_WIDTH  received word.
- PERR  out  1  parity error for word on DOUT.
- DVALID  out  1  DOUT/PERR valid.
- DREADY  in  1  consumer accepts when DVALID&DREADY.
- OVERRUN  out  1  sticky: a completed frame was dropped.
- ERR_CNT  out  ERR_CNT_WIDTH  saturating parity-error count.
- CLR  in  1  synchronous clear of ERR_CNT and OVERRUN.

## Operation
- States: IDLE, SHIFT, PAR.
- IDLE: SVALID&START → capture SIN as bit 0, bit count=1, acc=SIN, go SHIFT (PAR if DATA_WIDTH=1). Bits without START are ignored.
- SHIFT: each SVALID bit stored at index count, acc^=SIN, count++; after bit DATA_WIDTH-1 go PAR.
- PAR: SVALID bit is parity; error = acc ^ SIN ^ ODD_MODE (ODD_MODE sampled this cycle); frame complete; go IDLE, or directly SHIFT if START... see below.
- START with SVALID in SHIFT or PAR: current frame aborted silently (no output, no count); this bit becomes bit 0 of a new frame.
- Back-to-back: START on the cycle after the parity bit is accepted normally (state is IDLE then).
- SVALID=0: no state, count or accumulator change in any state.
- Frame completion with output register free (DVALID=0, or DVALID&DREADY same cycle): load DOUT, PERR, set DVALID.
- Completion with output held (DVALID&!DREADY): frame dropped, DOUT/PERR unchanged, OVERRUN←1.
- DVALID&DREADY without completion: DVALID←0.
- ERR_CNT increments on every completed frame with error, including dropped frames; saturates at all-ones.
- CLR: ERR_CNT←0, OVERRUN←0; CLR wins over a same-cycle increment or overrun set. Does not affect frame reception or DVALID.

## Timing
- Reset values: DOUT=0, PERR=0, DVALID=0, OVERRUN=0, ERR_CNT=0; state IDLE, count 0, acc 0.
- RST mid-frame discards partial frame; pending DVALID word lost.
- Latency: parity bit accepted in cycle N → DVALID/DOUT/PERR valid from cycle N+1; ERR_CNT updated in N+1.
- Minimum frame: DATA_WIDTH+1 cycles; sustained throughput one frame per DATA_WIDTH+1 cycles when DREADY held high.
- DOUT/PERR stable while DVALID&!DREADY.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package ttl_parity_pkg: state enum (IDLE, SHIFT, PAR), parity mode constants (PAR_EVEN=0, PAR_ODD=1).
- One sub-module natural: ttl_parity_shift (shift register, bit counter, XOR accumulator, frame-done strobe); top holds FSM, output register, counter, flags.

## Test plan
- Reset: RST pulsed after 3 bits of a frame → all outputs 0; next full frame received correctly.
- ODD_MODE=0, send 0xA5 (bits 1,0,1,0,0,1,0,1) + parity 0 → DOUT=0xA5, PERR=0, DVALID one cycle after parity; repeat with parity 1 → PERR=1, ERR_CNT=1.
- ODD_MODE=1, send 0x01 + parity 0 → PERR=0; 0x00 + parity 0 → PERR=1; SVALID gaps inserted mid-frame → same results.
- Abort: START re-asserted after 3 bits, then full 0x3C frame → single output 0x3C, ERR_CNT unchanged.
- Backpressure: DREADY=0, two frames 0x11 then 0x22 (second bad) → DOUT stays 0x11, OVERRUN=1, ERR_CNT=1; DREADY=1 → DVALID drops next cycle.
- ERR_CNT_WIDTH=2: five bad frames → ERR_CNT=3; CLR coincident with sixth bad completion → ERR_CNT=0, OVERRUN=0.

Source files
------------

// File: rtl/ttl_parity_pkg.sv
// Shared types for the serial parity receiver: FSM state encoding and parity modes.
package ttl_parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/ttl_parity_shift.sv
// Datapath for one frame: data shift register, bit counter, running XOR of data bits,
// and a strobe marking the accepted parity bit of a complete frame.
module ttl_parity_shift #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_start,
  input  logic                  i_in_shift,
  input  logic                  i_in_par,
  input  logic                  i_sin,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_acc,
  output logic                  o_last,
  output logic                  o_done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] r_data;
  logic [CW-1:0]         r_cnt;
  logic                  r_acc;

  // START always wins: a restart discards whatever frame was in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_acc  <= 1'b0;
    end else if (i_valid) begin
      if (i_start) begin
        r_data    <= '0;
        r_data[0] <= i_sin;
        r_cnt     <= CW'(1);
        r_acc     <= i_sin;
      end else if (i_in_shift) begin
        for (int i = 0; i < DATA_WIDTH; i++)
          if (r_cnt == CW'(i)) r_data[i] <= i_sin;
        r_cnt <= r_cnt + CW'(1);
        r_acc <= r_acc ^ i_sin;
      end else if (i_in_par) begin
        r_cnt <= '0;
        r_acc <= 1'b0;
      end
    end
  end

  assign o_data = r_data;
  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CW'(DATA_WIDTH - 1));
  assign o_done = i_valid & i_in_par & ~i_start;

endmodule

// File: rtl/ttl_serial_parity_checker.sv
// Bit-serial parity receiver: frame FSM, registered valid/ready output word with
// parity error flag, sticky overrun and saturating parity-error counter.
module ttl_serial_parity_checker
  import ttl_parity_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SIN,
  input  logic                     SVALID,
  input  logic                     START,
  input  logic                     ODD_MODE,
  output logic [DATA_WIDTH-1:0]    DOUT,
  output logic                     PERR,
  output logic                     DVALID,
  input  logic                     DREADY,
  output logic                     OVERRUN,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
  input  logic                     CLR
);

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    w_acc, w_last, w_done, w_err, w_free;
  logic                    w_start;

  logic [DATA_WIDTH-1:0]    r_dout;
  logic                     r_perr, r_dvalid, r_ovr;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  assign w_start = SVALID & START;

  ttl_parity_shift #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_valid    (SVALID),
    .i_start    (START),
    .i_in_shift (r_state == SHIFT),
    .i_in_par   (r_state == PAR),
    .i_sin      (SIN),
    .o_data     (w_data),
    .o_acc      (w_acc),
    .o_last     (w_last),
    .o_done     (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = (DATA_WIDTH == 1) ? PAR : SHIFT;
    end else if (SVALID) begin
      case (r_state)
        SHIFT:   if (w_last) w_state_nxt = PAR;
        PAR:     w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Error over data+parity: XOR of all bits must equal the selected mode.
  assign w_err  = w_acc ^ SIN ^ ODD_MODE;
  assign w_free = ~r_dvalid | DREADY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dout   <= '0;
      r_perr   <= 1'b0;
      r_dvalid <= 1'b0;
    end else if (w_done && w_free) begin
      r_dout   <= w_data;
      r_perr   <= w_err;
      r_dvalid <= 1'b1;
    end else if (r_dvalid && DREADY) begin
      r_dvalid <= 1'b0;
    end
  end

  // CLR takes priority over a same-cycle increment or overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err_cnt <= '0;
      r_ovr     <= 1'b0;
    end else if (CLR) begin
      r_err_cnt <= '0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_done && w_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
      if (w_done && !w_free)
        r_ovr <= 1'b1;
    end
  end

  assign DOUT    = r_dout;
  assign PERR    = r_perr;
  assign DVALID  = r_dvalid;
  assign OVERRUN = r_ovr;
  assign ERR_CNT = r_err_cnt;

endmodule
